// File: rtl/obj_mem_pkg.sv
// Shared definitions for the object memory unit.
//   NUM_OBJ / OBJ_W / IDX_W : slot count, record width, slot index width
//   stream_state_t          : states of the loadback stream FSM
//   *_LSB / *_MSB           : field positions inside a 144-bit object record
package obj_mem_pkg;

    localparam int NUM_OBJ = 32;
    localparam int OBJ_W   = 144;
    localparam int IDX_W   = 5;

    // Record layout: x/y coordinates, primitive type, color index
    localparam int XY_LSB    = 0;
    localparam int XY_MSB    = 127;
    localparam int TYPE_LSB  = 128;
    localparam int TYPE_MSB  = 129;
    localparam int COLOR_LSB = 130;
    localparam int COLOR_MSB = 137;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_SEND,
        ST_DONE
    } stream_state_t;

endpackage

// File: rtl/obj_alloc_penc.sv
// Find-lowest-set-bit priority encoder with a start-index mask.
// Bits of vec below start are ignored.
// Ports:
//   vec   : candidate bitmap
//   start : lowest index that may be reported
//   found : at least one bit at or above start is set
//   idx   : index of the lowest such bit (0 when none)
module obj_alloc_penc
    import obj_mem_pkg::*;
(
    input  logic [NUM_OBJ-1:0] vec,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_OBJ-1:0] masked;

    // Scanning from the top down lets the lowest set bit be the last assignment.
    always_comb begin
        masked = vec & ({NUM_OBJ{1'b1}} << start);
        found  = 1'b0;
        idx    = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/obj_mem_unit.sv
// Object memory and allocator serving the geometry unit, with a loadback
// stream of all valid objects towards the clipping unit.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   crt_obj/del_obj/del_all/ref_addr, obj_num : control pulses and slot index
//   wr_en/wr_data, rd_en       : record write/read at slot ref_ptr
//   rd_data/rd_vld             : registered read response
//   addr_vld, lst_stored_obj, lst_stored_obj_vld : create/reference response
//   obj_mem_full               : every slot valid
//   loadback, scan_busy        : stream start pulse and in-progress flag
//   stream_data/num/vld/rdy, stream_done : stream handshake and end pulse
// Optional: define OBJ_MEM_COUNT_EN to add obj_count (number of valid slots).
module obj_mem_unit
    import obj_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               crt_obj,
    input  logic               del_obj,
    input  logic               del_all,
    input  logic               ref_addr,
    input  logic [IDX_W-1:0]   obj_num,
    input  logic               wr_en,
    input  logic [OBJ_W-1:0]   wr_data,
    input  logic               rd_en,
    input  logic               loadback,
    output logic [OBJ_W-1:0]   rd_data,
    output logic               rd_vld,
    output logic               addr_vld,
    output logic [IDX_W-1:0]   lst_stored_obj,
    output logic               lst_stored_obj_vld,
    output logic               obj_mem_full,
    output logic               scan_busy,
    output logic [OBJ_W-1:0]   stream_data,
    output logic [IDX_W-1:0]   stream_num,
    output logic               stream_vld,
    input  logic               stream_rdy,
    output logic               stream_done
`ifdef OBJ_MEM_COUNT_EN
    ,
    output logic [IDX_W:0]     obj_count
`endif
);

    logic [OBJ_W-1:0]   mem [NUM_OBJ];
    logic [NUM_OBJ-1:0] valid;
    logic [IDX_W-1:0]   ref_ptr;
    logic [IDX_W-1:0]   seek_idx;
    stream_state_t      state;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               seek_found;
    logic [IDX_W-1:0]   seek_hit;

    obj_alloc_penc u_free_penc (
        .vec   (~valid),
        .start ('0),
        .found (free_found),
        .idx   (free_idx)
    );

    obj_alloc_penc u_seek_penc (
        .vec   (valid),
        .start (seek_idx),
        .found (seek_found),
        .idx   (seek_hit)
    );

    // Control pulses resolve in priority order del_all > del_obj > crt_obj > ref_addr;
    // all of them are frozen while a stream is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid              <= '0;
            ref_ptr            <= '0;
            addr_vld           <= 1'b0;
            lst_stored_obj     <= '0;
            lst_stored_obj_vld <= 1'b0;
            obj_mem_full       <= 1'b0;
        end else begin
            addr_vld     <= 1'b0;
            obj_mem_full <= &valid;
            if (!scan_busy) begin
                if (del_all) begin
                    valid <= '0;
                end else if (del_obj) begin
                    valid[obj_num] <= 1'b0;
                end else if (crt_obj) begin
                    addr_vld <= 1'b1;
                    if (free_found) begin
                        valid[free_idx]    <= 1'b1;
                        ref_ptr            <= free_idx;
                        lst_stored_obj     <= free_idx;
                        lst_stored_obj_vld <= 1'b1;
                    end else begin
                        lst_stored_obj_vld <= 1'b0;
                    end
                end else if (ref_addr) begin
                    ref_ptr            <= obj_num;
                    addr_vld           <= 1'b1;
                    lst_stored_obj     <= obj_num;
                    lst_stored_obj_vld <= valid[obj_num];
                end
            end
        end
    end

    // Record array is deliberately not reset; writes to invalid slots are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !scan_busy && valid[ref_ptr]) begin
            mem[ref_ptr] <= wr_data;
        end
    end

    // Reads ignore the valid bit and see pre-write data on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= mem[ref_ptr];
            end
        end
    end

    // Stream FSM: SEEK finds the next valid slot at or above seek_idx, SEND holds
    // the beat until accepted; the top slot ends the scan without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            seek_idx    <= '0;
            scan_busy   <= 1'b0;
            stream_vld  <= 1'b0;
            stream_done <= 1'b0;
            stream_data <= '0;
            stream_num  <= '0;
        end else begin
            stream_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (loadback) begin
                        state     <= ST_SEEK;
                        seek_idx  <= '0;
                        scan_busy <= 1'b1;
                    end
                end
                ST_SEEK: begin
                    if (seek_found) begin
                        stream_data <= mem[seek_hit];
                        stream_num  <= seek_hit;
                        stream_vld  <= 1'b1;
                        state       <= ST_SEND;
                    end else begin
                        state       <= ST_DONE;
                        stream_done <= 1'b1;
                        scan_busy   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (stream_rdy) begin
                        stream_vld <= 1'b0;
                        if (stream_num == IDX_W'(NUM_OBJ - 1)) begin
                            state       <= ST_DONE;
                            stream_done <= 1'b1;
                            scan_busy   <= 1'b0;
                        end else begin
                            seek_idx <= stream_num + IDX_W'(1);
                            state    <= ST_SEEK;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OBJ_MEM_COUNT_EN
    // Counter mirrors the bitmap: only successful creates and deletes of valid slots move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_count <= '0;
        end else if (!scan_busy) begin
            if (del_all) begin
                obj_count <= '0;
            end else if (del_obj) begin
                if (valid[obj_num]) begin
                    obj_count <= obj_count - (IDX_W + 1)'(1);
                end
            end else if (crt_obj && free_found) begin
                obj_count <= obj_count + (IDX_W + 1)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_obj_mem_unit.sv
// Directed self-checking bench for obj_mem_unit.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_obj_mem_unit;
    import obj_mem_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               crt_obj;
    logic               del_obj;
    logic               del_all;
    logic               ref_addr;
    logic [IDX_W-1:0]   obj_num;
    logic               wr_en;
    logic [OBJ_W-1:0]   wr_data;
    logic               rd_en;
    logic               loadback;
    logic [OBJ_W-1:0]   rd_data;
    logic               rd_vld;
    logic               addr_vld;
    logic [IDX_W-1:0]   lst_stored_obj;
    logic               lst_stored_obj_vld;
    logic               obj_mem_full;
    logic               scan_busy;
    logic [OBJ_W-1:0]   stream_data;
    logic [IDX_W-1:0]   stream_num;
    logic               stream_vld;
    logic               stream_rdy;
    logic               stream_done;
`ifdef OBJ_MEM_COUNT_EN
    logic [IDX_W:0]     obj_count;
`endif

    int errors = 0;
    int checks = 0;

    obj_mem_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .crt_obj            (crt_obj),
        .del_obj            (del_obj),
        .del_all            (del_all),
        .ref_addr           (ref_addr),
        .obj_num            (obj_num),
        .wr_en              (wr_en),
        .wr_data            (wr_data),
        .rd_en              (rd_en),
        .loadback           (loadback),
        .rd_data            (rd_data),
        .rd_vld             (rd_vld),
        .addr_vld           (addr_vld),
        .lst_stored_obj     (lst_stored_obj),
        .lst_stored_obj_vld (lst_stored_obj_vld),
        .obj_mem_full       (obj_mem_full),
        .scan_busy          (scan_busy),
        .stream_data        (stream_data),
        .stream_num         (stream_num),
        .stream_vld         (stream_vld),
        .stream_rdy         (stream_rdy),
        .stream_done        (stream_done)
`ifdef OBJ_MEM_COUNT_EN
        ,
        .obj_count          (obj_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [OBJ_W-1:0] observed,
                               input logic [OBJ_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [OBJ_W-1:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(i + 16);
        return {18{b}};
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [OBJ_W-1:0] a5;
        a5 = {18{8'hA5}};
        rst_n = 1'b0; crt_obj = 1'b0; del_obj = 1'b0; del_all = 1'b0; ref_addr = 1'b0;
        obj_num = '0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; loadback = 1'b0;
        stream_rdy = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_addr_vld", addr_vld, 0);
        checkOutput("rst_rd_vld", rd_vld, 0);
        checkOutput("rst_full", obj_mem_full, 0);
        checkOutput("rst_busy", scan_busy, 0);
        checkOutput("rst_stream_vld", stream_vld, 0);
        checkOutput("rst_stream_done", stream_done, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        applyStimulus();

        // Allocate, write, read back
        crt_obj = 1'b1;
        applyStimulus();
        crt_obj = 1'b0;
        checkOutput("alloc0_addr_vld", addr_vld, 1);
        checkOutput("alloc0_slot", lst_stored_obj, 0);
        checkOutput("alloc0_vld", lst_stored_obj_vld, 1);
        wr_en = 1'b1; wr_data = a5;
        applyStimulus();
        wr_en = 1'b0; rd_en = 1'b1;
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("read0_vld", rd_vld, 1);
        checkOutput("read0_data", rd_data, a5);
        applyStimulus();
        checkOutput("read0_vld_drop", rd_vld, 0);

        // Allocate until full, writing each slot with a distinct pattern
        doReset();
        for (int i = 0; i < NUM_OBJ; i++) begin
            crt_obj = 1'b1;
            applyStimulus();
            crt_obj = 1'b0;
            checkOutput($sformatf("fill_slot%0d", i), lst_stored_obj, i);
            checkOutput($sformatf("fill_vld%0d", i), lst_stored_obj_vld, 1);
            checkOutput($sformatf("fill_full%0d", i), obj_mem_full, 0);
            wr_en = 1'b1; wr_data = pattern(i);
            applyStimulus();
            wr_en = 1'b0;
        end
        checkOutput("full_flag", obj_mem_full, 1);
        crt_obj = 1'b1;
        applyStimulus();
        crt_obj = 1'b0;
        checkOutput("over_addr_vld", addr_vld, 1);
        checkOutput("over_vld", lst_stored_obj_vld, 0);
        del_obj = 1'b1; obj_num = 5'd7;
        applyStimulus();
        del_obj = 1'b0;
        checkOutput("del_no_resp", addr_vld, 0);
        applyStimulus();
        checkOutput("del_not_full", obj_mem_full, 0);
        crt_obj = 1'b1;
        applyStimulus();
        crt_obj = 1'b0;
        checkOutput("realloc_slot", lst_stored_obj, 7);
        checkOutput("realloc_vld", lst_stored_obj_vld, 1);

        // del_all beats crt_obj; writes to an invalid referenced slot are dropped
        del_all = 1'b1; crt_obj = 1'b1;
        applyStimulus();
        del_all = 1'b0; crt_obj = 1'b0;
        checkOutput("prio_no_addr_vld", addr_vld, 0);
        ref_addr = 1'b1; obj_num = 5'd3;
        applyStimulus();
        ref_addr = 1'b0;
        checkOutput("ref3_addr_vld", addr_vld, 1);
        checkOutput("ref3_slot", lst_stored_obj, 3);
        checkOutput("ref3_vld", lst_stored_obj_vld, 0);
        checkOutput("empty_not_full", obj_mem_full, 0);
        wr_en = 1'b1; wr_data = a5;
        applyStimulus();
        wr_en = 1'b0; rd_en = 1'b1;
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("drop_wr_rd_vld", rd_vld, 1);
        checkOutput("drop_wr_data", rd_data, pattern(3));

        // Leave exactly slots 2, 9, 31 valid
        for (int i = 0; i < NUM_OBJ; i++) begin
            crt_obj = 1'b1;
            applyStimulus();
        end
        crt_obj = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (i != 2 && i != 9 && i != 31) begin
                del_obj = 1'b1; obj_num = IDX_W'(i);
                applyStimulus();
            end
        end
        del_obj = 1'b0;

        // Stream with a 3-cycle stall on the first beat; crt_obj meanwhile is ignored
        loadback = 1'b1;
        applyStimulus();
        loadback = 1'b0;
        checkOutput("st_busy", scan_busy, 1);
        checkOutput("st_seek_vld", stream_vld, 0);
        crt_obj = 1'b1;
        applyStimulus();
        checkOutput("st_b0_vld", stream_vld, 1);
        checkOutput("st_b0_num", stream_num, 2);
        checkOutput("st_b0_data", stream_data, pattern(2));
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput($sformatf("st_hold%0d_vld", k), stream_vld, 1);
            checkOutput($sformatf("st_hold%0d_num", k), stream_num, 2);
            checkOutput($sformatf("st_hold%0d_data", k), stream_data, pattern(2));
        end
        crt_obj = 1'b0;
        checkOutput("st_crt_no_resp", addr_vld, 0);
        stream_rdy = 1'b1;
        applyStimulus();
        checkOutput("st_acc0_vld", stream_vld, 0);
        applyStimulus();
        checkOutput("st_b1_vld", stream_vld, 1);
        checkOutput("st_b1_num", stream_num, 9);
        checkOutput("st_b1_data", stream_data, pattern(9));
        applyStimulus();
        applyStimulus();
        checkOutput("st_b2_vld", stream_vld, 1);
        checkOutput("st_b2_num", stream_num, 31);
        checkOutput("st_b2_data", stream_data, pattern(31));
        checkOutput("st_b2_no_done", stream_done, 0);
        applyStimulus();
        stream_rdy = 1'b0;
        checkOutput("st_done", stream_done, 1);
        checkOutput("st_done_busy", scan_busy, 0);
        checkOutput("st_done_vld", stream_vld, 0);
        applyStimulus();
        checkOutput("st_done_pulse", stream_done, 0);
        ref_addr = 1'b1; obj_num = 5'd0;
        applyStimulus();
        ref_addr = 1'b0;
        checkOutput("st_crt_ignored", lst_stored_obj_vld, 0);

        // Empty bitmap stream
        del_all = 1'b1;
        applyStimulus();
        del_all = 1'b0;
        loadback = 1'b1;
        applyStimulus();
        loadback = 1'b0;
        checkOutput("empty_busy", scan_busy, 1);
        checkOutput("empty_no_done", stream_done, 0);
        applyStimulus();
        checkOutput("empty_done", stream_done, 1);
        checkOutput("empty_busy_off", scan_busy, 0);
        applyStimulus();

        // Reset during SEND aborts the stream asynchronously
        crt_obj = 1'b1;
        applyStimulus();
        crt_obj = 1'b0;
        loadback = 1'b1;
        applyStimulus();
        loadback = 1'b0;
        applyStimulus();
        checkOutput("abort_pre_vld", stream_vld, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_vld", stream_vld, 0);
        checkOutput("abort_busy", scan_busy, 0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("abort_no_done", stream_done, 0);

`ifdef OBJ_MEM_COUNT_EN
        doReset();
        for (int i = 0; i < 5; i++) begin
            crt_obj = 1'b1;
            applyStimulus();
        end
        crt_obj = 1'b0;
        del_obj = 1'b1; obj_num = 5'd0;
        applyStimulus();
        obj_num = 5'd1;
        applyStimulus();
        del_obj = 1'b0;
        checkOutput("count3", obj_count, 3);
        del_all = 1'b1;
        applyStimulus();
        del_all = 1'b0;
        checkOutput("count0", obj_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
